// File: rtl/opl3_reg_wr_arbiter.sv
// OPL3 register-write arbiter: grants host or sequencer writes round-robin,
// emits one-cycle register write pulses spaced at least WR_GAP cycles apart.
// Optional feature macro: OPL3_REG_WR_SAMPLE_ALIGN_EN -- holds writes to key-on /
// rhythm registers (0xB0-0xB8, 0xBD) until the next sample_clk_en pulse.

package opl3_reg_wr_pkg;

  // Register write payload presented to the register file
  typedef struct packed {
    logic       valid;
    logic       bank_num;
    logic [7:0] address;
    logic [7:0] data;
  } opl3_reg_wr_t;

endpackage

module opl3_reg_wr_arbiter
  import opl3_reg_wr_pkg::*;
#(
  parameter int unsigned WR_GAP = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         host_valid,
  output logic         host_ready,
  input  logic         host_bank_num,
  input  logic [7:0]   host_address,
  input  logic [7:0]   host_data,
  input  logic         seq_valid,
  output logic         seq_ready,
  input  logic         seq_bank_num,
  input  logic [7:0]   seq_address,
  input  logic [7:0]   seq_data,
  input  logic         sample_clk_en,
  output opl3_reg_wr_t opl3_reg_wr,
  output logic         busy
);

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 8;
  // GAP lasts WR_GAP-2 cycles; the counter counts down to zero inclusive
  localparam logic [CNT_W-1:0] GAP_LOAD = (WR_GAP > 2) ? CNT_W'(WR_GAP - 3) : '0;
  localparam bit               NO_GAP   = (WR_GAP <= 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OUT  = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t              state;
  logic                last_seq;
  logic                pend_bank;
  logic [ADDR_W-1:0]   pend_addr;
  logic [DATA_W-1:0]   pend_data;
  logic [CNT_W-1:0]    gap_cnt;

  logic                grant_host;
  logic                grant_seq;
  logic                xfer_host;
  logic                xfer_seq;
  logic                sel_bank;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic                align_hit;

  // Round-robin grant: on contention the requester not granted last time wins
  assign grant_host = host_valid && (!seq_valid || last_seq);
  assign grant_seq  = seq_valid && (!host_valid || !last_seq);

  // Ready is a decode of the grant, so only offered while IDLE
  assign host_ready = (state == IDLE) && grant_host;
  assign seq_ready  = (state == IDLE) && grant_seq;

  assign xfer_host = host_valid && host_ready;
  assign xfer_seq  = seq_valid && seq_ready;

  // Payload of the transferring requester
  assign sel_bank = xfer_seq ? seq_bank_num : host_bank_num;
  assign sel_addr = xfer_seq ? seq_address  : host_address;
  assign sel_data = xfer_seq ? seq_data     : host_data;

`ifdef OPL3_REG_WR_SAMPLE_ALIGN_EN
  // Key-on / rhythm writes are aligned to the sample boundary
  assign align_hit = ((sel_addr >= 8'hB0) && (sel_addr <= 8'hB8)) || (sel_addr == 8'hBD);
`else
  assign align_hit = 1'b0;
`endif

  // Arbitration FSM with registered write output and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last_seq    <= 1'b1;
      pend_bank   <= 1'b0;
      pend_addr   <= '0;
      pend_data   <= '0;
      gap_cnt     <= '0;
      opl3_reg_wr <= '0;
      busy        <= 1'b0;
    end else begin
      opl3_reg_wr.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_host || xfer_seq) begin
            last_seq <= xfer_seq;
            busy     <= 1'b1;
            if (align_hit) begin
              pend_bank <= sel_bank;
              pend_addr <= sel_addr;
              pend_data <= sel_data;
              state     <= HOLD;
            end else begin
              opl3_reg_wr <= '{valid: 1'b1, bank_num: sel_bank, address: sel_addr, data: sel_data};
              state       <= OUT;
            end
          end
        end
        HOLD: begin
          if (sample_clk_en) begin
            opl3_reg_wr <= '{valid: 1'b1, bank_num: pend_bank, address: pend_addr, data: pend_data};
            state       <= OUT;
          end
        end
        OUT: begin
          if (NO_GAP) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= GAP_LOAD;
            state   <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opl3_reg_wr_arbiter.sv
// Scoreboard bench for opl3_reg_wr_arbiter: WR_GAP=4 and WR_GAP=2 instances.
module tb_opl3_reg_wr_arbiter;
  import opl3_reg_wr_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic sample_clk_en;

  logic         h4_valid, h4_ready, h4_bank;
  logic [7:0]   h4_addr, h4_data;
  logic         s4_valid, s4_ready, s4_bank;
  logic [7:0]   s4_addr, s4_data;
  opl3_reg_wr_t wr4;
  logic         busy4;

  logic         h2_valid, h2_ready, h2_bank;
  logic [7:0]   h2_addr, h2_data;
  logic         s2_valid, s2_ready, s2_bank;
  logic [7:0]   s2_addr, s2_data;
  opl3_reg_wr_t wr2;
  logic         busy2;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int bank;
    int addr;
    int data;
    int exp_cyc;
    int exp_gap;
  } exp_t;

  exp_t q4[$];
  exp_t q2[$];
  int last4 = 0;
  int last2 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  opl3_reg_wr_arbiter #(.WR_GAP(4)) dut4 (
    .clk(clk), .reset(reset),
    .host_valid(h4_valid), .host_ready(h4_ready),
    .host_bank_num(h4_bank), .host_address(h4_addr), .host_data(h4_data),
    .seq_valid(s4_valid), .seq_ready(s4_ready),
    .seq_bank_num(s4_bank), .seq_address(s4_addr), .seq_data(s4_data),
    .sample_clk_en(sample_clk_en), .opl3_reg_wr(wr4), .busy(busy4)
  );

  opl3_reg_wr_arbiter #(.WR_GAP(2)) dut2 (
    .clk(clk), .reset(reset),
    .host_valid(h2_valid), .host_ready(h2_ready),
    .host_bank_num(h2_bank), .host_address(h2_addr), .host_data(h2_data),
    .seq_valid(s2_valid), .seq_ready(s2_ready),
    .seq_bank_num(s2_bank), .seq_address(s2_addr), .seq_data(s2_data),
    .sample_clk_en(sample_clk_en), .opl3_reg_wr(wr2), .busy(busy2)
  );

  function automatic void chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic exp_t mk(input int b, input int a, input int d, input int c, input int g);
    exp_t e;
    e.bank = b; e.addr = a; e.data = d; e.exp_cyc = c; e.exp_gap = g;
    return e;
  endfunction

  // Monitor for the WR_GAP=4 instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (!reset && wr4.valid) begin
      if (q4.size() == 0) begin
        total++; bad++;
        $display("FAIL wr4_unexpected: got write addr 0x%0h, required no write (cyc %0d)", wr4.address, cyc);
      end else begin
        e = q4.pop_front();
        chk("wr4_bank", int'(wr4.bank_num), e.bank);
        chk("wr4_addr", int'(wr4.address), e.addr);
        chk("wr4_data", int'(wr4.data), e.data);
        if (e.exp_cyc >= 0) chk("wr4_cycle", cyc, e.exp_cyc);
        if (e.exp_gap >= 0) chk("wr4_gap", cyc - last4, e.exp_gap);
      end
      last4 = cyc;
    end
  end

  // Monitor for the WR_GAP=2 instance
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!reset && wr2.valid) begin
      if (q2.size() == 0) begin
        total++; bad++;
        $display("FAIL wr2_unexpected: got write addr 0x%0h, required no write (cyc %0d)", wr2.address, cyc);
      end else begin
        e = q2.pop_front();
        chk("wr2_bank", int'(wr2.bank_num), e.bank);
        chk("wr2_addr", int'(wr2.address), e.addr);
        chk("wr2_data", int'(wr2.data), e.data);
        if (e.exp_cyc >= 0) chk("wr2_cycle", cyc, e.exp_cyc);
        if (e.exp_gap >= 0) chk("wr2_gap", cyc - last2, e.exp_gap);
      end
      last2 = cyc;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Requester drivers: called on a negedge, return on the negedge after transfer
  task automatic host4_wr(input logic b, input logic [7:0] a, input logic [7:0] d);
    bit done = 1'b0;
    h4_bank = b; h4_addr = a; h4_data = d; h4_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (h4_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    h4_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL host4_handshake: got no ready in 64 cycles, required a transfer");
    end
  endtask

  task automatic seq4_wr(input logic b, input logic [7:0] a, input logic [7:0] d);
    bit done = 1'b0;
    s4_bank = b; s4_addr = a; s4_data = d; s4_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (s4_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    s4_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL seq4_handshake: got no ready in 64 cycles, required a transfer");
    end
  endtask

  task automatic seq2_wr(input logic b, input logic [7:0] a, input logic [7:0] d);
    bit done = 1'b0;
    s2_bank = b; s2_addr = a; s2_data = d; s2_valid = 1'b1;
    for (int i = 0; i < 64 && !done; i++) begin
      #1;
      if (s2_ready) begin
        @(posedge clk);
        done = 1'b1;
      end
      @(negedge clk);
    end
    s2_valid = 1'b0;
    if (!done) begin
      total++; bad++;
      $display("FAIL seq2_handshake: got no ready in 64 cycles, required a transfer");
    end
  endtask

  int k;

  initial begin
    reset = 1'b1; sample_clk_en = 1'b0;
    h4_valid = 1'b0; h4_bank = 1'b0; h4_addr = 8'h00; h4_data = 8'h00;
    s4_valid = 1'b0; s4_bank = 1'b0; s4_addr = 8'h00; s4_data = 8'h00;
    h2_valid = 1'b0; h2_bank = 1'b0; h2_addr = 8'h00; h2_data = 8'h00;
    s2_valid = 1'b0; s2_bank = 1'b0; s2_addr = 8'h00; s2_data = 8'h00;
    wait_cycles(3);
    // Reset state
    chk("rst_wr4", int'(wr4), 0);
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_wr2", int'(wr2), 0);
    chk("rst_busy2", int'(busy2), 0);
    reset = 1'b0;
    wait_cycles(2);

    // Contention after reset: host first, then alternate, 4-cycle spacing
    k = cyc;
    q4.push_back(mk(0, 'h40, 'hA1, k + 1, -1));
    q4.push_back(mk(1, 'h60, 'hB1, -1, 4));
    q4.push_back(mk(0, 'h40, 'hA2, -1, 4));
    fork
      begin host4_wr(1'b0, 8'h40, 8'hA1); host4_wr(1'b0, 8'h40, 8'hA2); end
      begin seq4_wr(1'b1, 8'h60, 8'hB1); end
    join
    wait_cycles(8);

    // Single write: valid one cycle after accept, busy for WR_GAP-1 cycles
    k = cyc;
    q4.push_back(mk(1, 'h20, 'h21, k + 1, -1));
    host4_wr(1'b1, 8'h20, 8'h21);
    chk("single_busy_c1", int'(busy4), 1);
    wait_cycles(1); chk("single_busy_c2", int'(busy4), 1);
    wait_cycles(1); chk("single_busy_c3", int'(busy4), 1);
    wait_cycles(1); chk("single_busy_c4", int'(busy4), 0);
    chk("single_fields_hold", int'(wr4.address), 'h20);

    // Valid withdrawn before grant: nothing is emitted for it
    k = cyc;
    q4.push_back(mk(0, 'h33, 'h44, k + 1, -1));
    host4_wr(1'b0, 8'h33, 8'h44);
    s4_bank = 1'b1; s4_addr = 8'h99; s4_data = 8'h99; s4_valid = 1'b1;
    wait_cycles(1);
    s4_valid = 1'b0;
    wait_cycles(8);

    // Minimum gap: WR_GAP=2 streaming sequencer
    k = cyc;
    q2.push_back(mk(0, 'h10, 'h01, k + 1, -1));
    q2.push_back(mk(0, 'h11, 'h02, -1, 2));
    q2.push_back(mk(1, 'h12, 'h03, -1, 2));
    seq2_wr(1'b0, 8'h10, 8'h01);
    seq2_wr(1'b0, 8'h11, 8'h02);
    seq2_wr(1'b1, 8'h12, 8'h03);
    wait_cycles(6);

`ifdef OPL3_REG_WR_SAMPLE_ALIGN_EN
    // Aligned write: sample pulse in accept cycle ignored, released by later pulse
    k = cyc;
    q4.push_back(mk(0, 'hB0, 'h31, k + 21, -1));
    sample_clk_en = 1'b1;
    host4_wr(1'b0, 8'hB0, 8'h31);
    sample_clk_en = 1'b0;
    chk("hold_busy_start", int'(busy4), 1);
    wait_cycles(9); chk("hold_busy_mid", int'(busy4), 1);
    wait_cycles(10);
    sample_clk_en = 1'b1;
    wait_cycles(1);
    sample_clk_en = 1'b0;
    wait_cycles(2); chk("hold_busy_gap", int'(busy4), 1);
    wait_cycles(1); chk("hold_busy_end", int'(busy4), 0);
    wait_cycles(2);
    k = cyc;
    q4.push_back(mk(0, 'hA0, 'h32, k + 1, -1));
    host4_wr(1'b0, 8'hA0, 8'h32);
    wait_cycles(6);

    // Reset during HOLD discards the pending write
    host4_wr(1'b1, 8'hB4, 8'h55);
    wait_cycles(2);
    reset = 1'b1;
    wait_cycles(1);
`else
    // Without alignment 0xBD goes straight out, sample_clk_en ignored
    k = cyc;
    q4.push_back(mk(1, 'hBD, 'h3F, k + 1, -1));
    sample_clk_en = 1'b1;
    host4_wr(1'b1, 8'hBD, 8'h3F);
    sample_clk_en = 1'b0;
    wait_cycles(6);
    k = cyc;
    q4.push_back(mk(0, 'hB0, 'h31, k + 1, -1));
    host4_wr(1'b0, 8'hB0, 8'h31);
    wait_cycles(6);

    // Reset during GAP
    k = cyc;
    q4.push_back(mk(1, 'h55, 'h66, k + 1, -1));
    host4_wr(1'b1, 8'h55, 8'h66);
    wait_cycles(1);
    reset = 1'b1;
    wait_cycles(1);
`endif
    // Outputs cleared the cycle after reset
    chk("post_rst_wr4", int'(wr4), 0);
    chk("post_rst_busy4", int'(busy4), 0);
    chk("post_rst_ready4", int'({h4_ready, s4_ready}), 0);
    reset = 1'b0;
    sample_clk_en = 1'b1;
    wait_cycles(1);
    sample_clk_en = 1'b0;
    wait_cycles(4);

    // Host wins the first contention after reset
    k = cyc;
    q4.push_back(mk(0, 'h70, 'h07, k + 1, -1));
    q4.push_back(mk(1, 'h71, 'h08, -1, 4));
    fork
      host4_wr(1'b0, 8'h70, 8'h07);
      seq4_wr(1'b1, 8'h71, 8'h08);
    join

    // Drain scoreboard with a bound
    for (int i = 0; i < 50 && (q4.size() != 0 || q2.size() != 0); i++) wait_cycles(1);
    wait_cycles(8);
    chk("q4_left", q4.size(), 0);
    chk("q2_left", q2.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
